dsp_mac_pipe: RTL and testbench
===============================

DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

Interface
REQ-001 SHALL provide parameter AW, default 18, A operand width (2..27).
REQ-002 SHALL provide parameter BW, default 18, B operand width (2..27).
REQ-003 SHALL provide parameter PW, default 48, accumulator/P width; AW+BW < PW is required, elaboration error otherwise.
REQ-004 SHALL provide parameter MSTAGES, default 2, multiplier pipeline registers (1..4).
REQ-005 SHALL provide parameter SATURATE, default 1; 1 = clamp on overflow, 0 = wrap.
REQ-006 SHALL provide port CLK, input, 1, sole clock, rising edge.
REQ-007 SHALL provide port RSTN, input, 1; reset is asynchronous and active-low.
REQ-008 SHALL provide ports IN_VALID in 1, IN_READY out 1: input handshake.
REQ-009 SHALL provide ports A in AW, B in BW, C in PW: signed two's-complement operands.
REQ-010 SHALL provide port OP, input, 2: 00 P=A*B, 01 P=A*B+C, 10 acc+=A*B, 11 acc-=A*B.
REQ-011 SHALL provide port LAST, input, 1: closes an accumulate burst (OP 1x only).
REQ-012 SHALL provide ports OUT_VALID out 1, OUT_READY in 1: output handshake.
REQ-013 SHALL provide port P, output, PW: result.
REQ-014 SHALL provide port OVF, output, 1: overflow occurred in the result's computation (sticky within a burst).
REQ-015 SHALL provide port CNT, output, 16: number of samples folded into P (saturates at 0xFFFF).

Function
REQ-016 SHALL accept a sample when IN_VALID && IN_READY on a rising edge.
REQ-017 SHALL drive IN_READY = !(OUT_VALID && !OUT_READY); the pipeline SHALL advance only while not stalled.
REQ-018 SHALL compute A*B sign-extended to PW through MSTAGES registers; latency from accept to OUT_VALID = MSTAGES+1 cycles with no stall.
REQ-019 SHALL emit a result for every OP 0x sample and only for the LAST sample of an OP 1x burst; non-LAST OP 1x samples SHALL update the accumulator without OUT_VALID.
REQ-020 SHALL keep accumulator state IDLE/ACCUM: IDLE + OP 1x -> ACCUM with acc = ±A*B, CNT=1; ACCUM + OP 1x -> acc updated, CNT+1; LAST -> result emitted, acc cleared, IDLE.
REQ-021 SHALL, if an OP 0x sample arrives in ACCUM, emit it normally and leave the accumulator and CNT untouched.
REQ-022 SHALL detect overflow as signed PW-bit overflow of the add/subtract; SATURATE=1 clamps to 2^(PW-1)-1 or -2^(PW-1); SATURATE=0 wraps.
REQ-023 SHALL hold P, OVF, CNT stable while OUT_VALID && !OUT_READY; OUT_VALID SHALL drop the cycle after the handshake unless a new result is ready.
REQ-024 SHALL report CNT=1 for OP 0x results.
REQ-025 SHALL treat IN_VALID with LAST=1 and OP 1x in IDLE as a one-sample burst.

Reset
REQ-026 SHALL, on RSTN low, immediately clear all pipeline valids, accumulator, state (IDLE), P=0, OVF=0, CNT=0, OUT_VALID=0; IN_READY=1.
REQ-027 SHALL discard all in-flight samples and any partial burst on reset; first edge after RSTN rises SHALL be able to accept.

Verification
REQ-028 SHALL test MSTAGES=2: A=3,B=-4,OP=00, OUT_READY=1 -> OUT_VALID exactly 3 cycles later, P=-12, CNT=1, OVF=0.
REQ-029 SHALL test burst OP=10 of (2,5),(3,3),(1,-7) with LAST on third -> single result P=12, CNT=3; OP=11 same data -> P=-12.
REQ-030 SHALL test PW=48 SATURATE=1: accumulate (2^17-1)*(2^17-1) repeatedly until overflow -> P=0x7FFF_FFFF_FFFF, OVF=1; SATURATE=0 -> wrapped value, OVF=1.
REQ-031 SHALL test backpressure: OUT_READY=0 for 5 cycles with continuous IN_VALID -> IN_READY=0, P held, no sample lost or duplicated after release.
REQ-032 SHALL test RSTN pulsed low mid-burst after 2 samples -> outputs zero immediately; new burst of (4,4) LAST -> P=16, CNT=1.
REQ-033 SHALL test OP=01 inserted in ACCUM: A=1,B=1,C=100 -> P=101 emitted; following LAST burst total unaffected.

Source files
------------

// File: rtl/dsp_mac_pipe.sv
// Pipelined signed multiply / multiply-add / accumulate unit.
// Operand register, MSTAGES product registers, then an accumulate/output stage.
module dsp_mac_pipe #(
   parameter int AW       = 18,
   parameter int BW       = 18,
   parameter int PW       = 48,
   parameter int MSTAGES  = 2,
   parameter int SATURATE = 1
) (
   input  logic          CLK,
   input  logic          RSTN,
   input  logic          IN_VALID,
   output logic          IN_READY,
   input  logic [AW-1:0] A,
   input  logic [BW-1:0] B,
   input  logic [PW-1:0] C,
   input  logic [1:0]    OP,
   input  logic          LAST,
   output logic          OUT_VALID,
   input  logic          OUT_READY,
   output logic [PW-1:0] P,
   output logic          OVF,
   output logic [15:0]   CNT
);

   localparam int MW = AW + BW;
   localparam logic [PW-1:0] PMAX = {1'b0, {(PW-1){1'b1}}};
   localparam logic [PW-1:0] PMIN = {1'b1, {(PW-1){1'b0}}};

   if (AW + BW >= PW) begin : g_pw_chk
      $error("dsp_mac_pipe: AW+BW must be less than PW");
   end
   if (MSTAGES < 1 || MSTAGES > 4) begin : g_ms_chk
      $error("dsp_mac_pipe: MSTAGES must be 1..4");
   end

   typedef struct packed {
      logic          v;
      logic [1:0]    op;
      logic          last;
      logic [PW-1:0] c;
      logic [AW-1:0] a;
      logic [BW-1:0] b;
   } opnd_t;

   typedef struct packed {
      logic          v;
      logic [1:0]    op;
      logic          last;
      logic [PW-1:0] c;
      logic [MW-1:0] prod;
   } mst_t;

   typedef enum logic {S_IDLE, S_ACCUM} state_e;

   opnd_t   opnd_q, opnd_d;
   mst_t    mst_q [MSTAGES];
   mst_t    mst_d [MSTAGES];
   mst_t    fin;
   state_e  state_q, state_d;

   logic [PW-1:0] acc_q, acc_d;
   logic          acc_ovf_q, acc_ovf_d;
   logic [15:0]   acc_cnt_q, acc_cnt_d;
   logic          out_v_q, out_v_d;
   logic [PW-1:0] p_q, p_d;
   logic          ovf_q, ovf_d;
   logic [15:0]   cnt_q, cnt_d;

   logic                 adv;
   logic signed [MW-1:0] ax, bx;
   logic [PW-1:0]        prod_x, base, addend, res;
   logic [PW:0]          sum_x;
   logic                 of, acc_live, ovf_base;
   logic [15:0]          cnt_base, cnt_inc;

   assign adv       = !(out_v_q && !OUT_READY);
   assign IN_READY  = adv;
   assign OUT_VALID = out_v_q;
   assign P         = p_q;
   assign OVF       = ovf_q;
   assign CNT       = cnt_q;

   assign fin    = mst_q[MSTAGES-1];
   assign prod_x = {{(PW-MW){fin.prod[MW-1]}}, fin.prod};

   always_comb begin
      opnd_d = opnd_q;
      mst_d  = mst_q;
      ax     = MW'($signed(opnd_q.a));
      bx     = MW'($signed(opnd_q.b));
      if (adv) begin
         opnd_d.v = IN_VALID;
         if (IN_VALID) begin
            opnd_d.op   = OP;
            opnd_d.last = LAST;
            opnd_d.c    = C;
            opnd_d.a    = A;
            opnd_d.b    = B;
         end
         mst_d[0].v    = opnd_q.v;
         mst_d[0].op   = opnd_q.op;
         mst_d[0].last = opnd_q.last;
         mst_d[0].c    = opnd_q.c;
         mst_d[0].prod = ax * bx;
         for (int i = 1; i < MSTAGES; i++) begin
            mst_d[i] = mst_q[i-1];
         end
      end
   end

   // One signed adder serves both C-add and accumulate; PW+1 bits expose overflow
   always_comb begin
      acc_live = (state_q == S_ACCUM);
      base     = '0;
      addend   = prod_x;
      if (fin.op[1]) begin
         if (acc_live) base = acc_q;
         if (fin.op[0]) addend = -prod_x;
      end else if (fin.op[0]) begin
         base = fin.c;
      end
      sum_x = {base[PW-1], base} + {addend[PW-1], addend};
      of    = sum_x[PW] ^ sum_x[PW-1];
      res   = sum_x[PW-1:0];
      if (of && SATURATE != 0) begin
         res = sum_x[PW] ? PMIN : PMAX;
      end
      ovf_base = acc_live ? acc_ovf_q : 1'b0;
      cnt_base = acc_live ? acc_cnt_q : 16'd0;
      cnt_inc  = (cnt_base == 16'hFFFF) ? cnt_base : cnt_base + 16'd1;
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      acc_ovf_d = acc_ovf_q;
      acc_cnt_d = acc_cnt_q;
      out_v_d   = out_v_q;
      p_d       = p_q;
      ovf_d     = ovf_q;
      cnt_d     = cnt_q;
      if (adv) begin
         out_v_d = 1'b0;
         if (fin.v) begin
            unique case (1'b1)
               !fin.op[1]: begin
                  out_v_d = 1'b1;
                  p_d     = res;
                  ovf_d   = of;
                  cnt_d   = 16'd1;
               end
               fin.op[1] && fin.last: begin
                  out_v_d   = 1'b1;
                  p_d       = res;
                  ovf_d     = ovf_base | of;
                  cnt_d     = cnt_inc;
                  state_d   = S_IDLE;
                  acc_d     = '0;
                  acc_ovf_d = 1'b0;
                  acc_cnt_d = '0;
               end
               fin.op[1] && !fin.last: begin
                  state_d   = S_ACCUM;
                  acc_d     = res;
                  acc_ovf_d = ovf_base | of;
                  acc_cnt_d = cnt_inc;
               end
            endcase
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         opnd_q <= '0;
         for (int i = 0; i < MSTAGES; i++) begin
            mst_q[i] <= '0;
         end
         state_q   <= S_IDLE;
         acc_q     <= '0;
         acc_ovf_q <= 1'b0;
         acc_cnt_q <= '0;
         out_v_q   <= 1'b0;
         p_q       <= '0;
         ovf_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         opnd_q    <= opnd_d;
         mst_q     <= mst_d;
         state_q   <= state_d;
         acc_q     <= acc_d;
         acc_ovf_q <= acc_ovf_d;
         acc_cnt_q <= acc_cnt_d;
         out_v_q   <= out_v_d;
         p_q       <= p_d;
         ovf_q     <= ovf_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Bench for dsp_mac_pipe: saturating and wrapping instances share stimulus,
// each scored against an arithmetic model of the MAC rules.
module tb_dsp_mac_pipe;

   localparam int AW = 18;
   localparam int BW = 18;
   localparam int PW = 48;
   localparam int MS = 2;
   localparam longint MAXP  = (64'sd1 <<< 47) - 64'sd1;
   localparam longint MINP  = -(64'sd1 <<< 47);
   localparam longint TWO48 = 64'sd1 <<< 48;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          in_valid = 1'b0;
   logic [AW-1:0] a = '0;
   logic [BW-1:0] b = '0;
   logic [PW-1:0] c = '0;
   logic [1:0]    op = '0;
   logic          last = 1'b0;
   logic          out_ready;

   logic          ir_s, ov_s, of_s, ir_w, ov_w, of_w;
   logic [PW-1:0] p_s, p_w;
   logic [15:0]   cnt_s, cnt_w;

   always #5 clk = ~clk;

   dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW), .MSTAGES(MS), .SATURATE(1)) u_sat (
      .CLK(clk), .RSTN(rstn), .IN_VALID(in_valid), .IN_READY(ir_s),
      .A(a), .B(b), .C(c), .OP(op), .LAST(last),
      .OUT_VALID(ov_s), .OUT_READY(out_ready), .P(p_s), .OVF(of_s), .CNT(cnt_s)
   );

   dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW), .MSTAGES(MS), .SATURATE(0)) u_wrap (
      .CLK(clk), .RSTN(rstn), .IN_VALID(in_valid), .IN_READY(ir_w),
      .A(a), .B(b), .C(c), .OP(op), .LAST(last),
      .OUT_VALID(ov_w), .OUT_READY(out_ready), .P(p_w), .OVF(of_w), .CNT(cnt_w)
   );

   typedef struct {
      logic [47:0] p;
      logic        ovf;
      logic [15:0] cnt;
   } exp_t;

   int n_err = 0;
   int n_chk = 0;
   int rmode = 0;

   exp_t        q0[$];
   exp_t        q1[$];
   longint      m_acc [2];
   bit          m_ovf [2];
   int          m_cnt [2];
   bit          m_busy [2];
   logic [47:0] lp [2];
   logic        lo [2];
   logic [15:0] lc [2];
   int          nout [2];
   bit          st [2];
   logic [47:0] sp [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic longint fix(input longint x, input bit sat, output bit of);
      of = (x > MAXP) || (x < MINP);
      if (!of) return x;
      if (sat) return (x > MAXP) ? MAXP : MINP;
      return (x > MAXP) ? x - TWO48 : x + TWO48;
   endfunction

   task automatic model(input int v, input longint pa, input longint pb,
                        input longint pc, input logic [1:0] o, input logic l);
      longint prod, r;
      bit     of, emit, sat;
      exp_t   e;
      sat   = (v == 0);
      prod  = pa * pb;
      emit  = 0;
      e.cnt = 16'd1;
      e.ovf = 1'b0;
      e.p   = '0;
      if (!o[1]) begin
         r     = fix(prod + (o[0] ? pc : 64'sd0), sat, of);
         e.p   = r[47:0];
         e.ovf = of;
         emit  = 1;
      end else begin
         if (!m_busy[v]) begin
            m_acc[v] = 0;
            m_ovf[v] = 0;
            m_cnt[v] = 0;
         end
         r = fix(m_acc[v] + (o[0] ? -prod : prod), sat, of);
         m_ovf[v] = m_ovf[v] | of;
         m_cnt[v] = (m_cnt[v] < 65535) ? m_cnt[v] + 1 : 65535;
         if (l) begin
            e.p   = r[47:0];
            e.ovf = m_ovf[v];
            e.cnt = 16'(m_cnt[v]);
            emit  = 1;
            m_busy[v] = 0;
         end else begin
            m_acc[v]  = r;
            m_busy[v] = 1;
         end
      end
      if (emit) begin
         if (v == 0) q0.push_back(e);
         else q1.push_back(e);
      end
   endtask

   task automatic mon(input int v, input logic ovl, input logic [47:0] pp,
                      input logic ofl, input logic [15:0] cc, input logic ir);
      exp_t e;
      bit   has;
      if (!rstn) begin
         if (v == 0) q0.delete();
         else q1.delete();
         m_busy[v] = 0;
         st[v] = 0;
         return;
      end
      if (st[v]) begin
         chk("hold_valid", 64'(ovl), 64'd1);
         if (ovl) chk("hold_p", 64'(pp), 64'(sp[v]));
      end
      if (ovl && out_ready) begin
         has = (v == 0) ? (q0.size() != 0) : (q1.size() != 0);
         chk("out_expected", 64'(has), 64'd1);
         if (has) begin
            e = (v == 0) ? q0.pop_front() : q1.pop_front();
            chk(v == 0 ? "p_sat" : "p_wrap", 64'(pp), 64'(e.p));
            chk(v == 0 ? "ovf_sat" : "ovf_wrap", 64'(ofl), 64'(e.ovf));
            chk(v == 0 ? "cnt_sat" : "cnt_wrap", 64'(cc), 64'(e.cnt));
         end
         lp[v] = pp;
         lo[v] = ofl;
         lc[v] = cc;
         nout[v]++;
      end
      st[v] = ovl && !out_ready;
      sp[v] = pp;
      if (in_valid && ir) begin
         model(v, longint'($signed(a)), longint'($signed(b)),
               longint'($signed(c)), op, last);
      end
   endtask

   always @(negedge clk) begin
      mon(0, ov_s, p_s, of_s, cnt_s, ir_s);
      mon(1, ov_w, p_w, of_w, cnt_w, ir_w);
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic send(input longint pa, input longint pb, input longint pc,
                       input logic [1:0] o, input logic l, output int w);
      a  = pa[AW-1:0];
      b  = pb[BW-1:0];
      c  = pc[PW-1:0];
      op = o;
      last = l;
      in_valid = 1'b1;
      w = 0;
      forever begin
         @(negedge clk);
         if (ir_s) begin
            @(posedge clk);
            #1;
            break;
         end
         w++;
         if (w > 1000) begin
            chk("send_timeout", 64'(w), 64'd0);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      rmode = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_drain"}, 64'(q0.size() + q1.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int w, k, n0;
      logic signed [AW-1:0] ra;
      logic signed [BW-1:0] rb;
      logic signed [PW-1:0] rc;
      longint wrap30;

      #1;
      chk("rst_valid", 64'(ov_s), 64'd0);
      chk("rst_ready", 64'(ir_s), 64'd1);
      chk("rst_p", 64'(p_s), 64'd0);
      chk("rst_ovf", 64'(of_s), 64'd0);
      chk("rst_cnt", 64'(cnt_s), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;

      send(3, -4, 0, 2'b00, 0, w);
      k = 0;
      while (!ov_s && k < 10) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("latency", 64'(k), 64'd3);
      drain("t28");
      chk("t28_p", 64'(lp[0]), 64'h0000_FFFF_FFFF_FFF4);
      chk("t28_cnt", 64'(lc[0]), 64'd1);
      chk("t28_ovf", 64'(lo[0]), 64'd0);

      send(2, 5, 0, 2'b10, 0, w);
      send(3, 3, 0, 2'b10, 0, w);
      send(1, -7, 0, 2'b10, 1, w);
      drain("t29a");
      chk("t29_add_p", 64'(lp[0]), 64'd12);
      chk("t29_add_cnt", 64'(lc[0]), 64'd3);
      send(2, 5, 0, 2'b11, 0, w);
      send(3, 3, 0, 2'b11, 0, w);
      send(1, -7, 0, 2'b11, 1, w);
      drain("t29b");
      chk("t29_sub_p", 64'(lp[0]), 64'h0000_FFFF_FFFF_FFF4);

      send(2, 5, 0, 2'b10, 0, w);
      send(1, 1, 100, 2'b01, 0, w);
      drain("t33a");
      chk("t33_madd_p", 64'(lp[0]), 64'd101);
      send(3, 3, 0, 2'b10, 1, w);
      drain("t33b");
      chk("t33_burst_p", 64'(lp[0]), 64'd19);
      chk("t33_burst_cnt", 64'(lc[0]), 64'd2);

      n0 = nout[0];
      rmode = 1;
      @(posedge clk);
      #1;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               send(longint'(i + 1), longint'(i * 3 - 7), 0, 2'b00, 0, w);
            end
         end
         begin
            k = 0;
            while (!ov_s && k < 20) begin
               @(posedge clk);
               #2;
               k++;
            end
            chk("bp_valid_seen", 64'(ov_s), 64'd1);
            repeat (5) begin
               @(posedge clk);
               #2;
               chk("bp_in_ready", 64'(ir_s), 64'd0);
            end
            rmode = 0;
         end
      join
      drain("bp");
      chk("bp_count", 64'(nout[0] - n0), 64'd10);

      rmode = 1;
      @(posedge clk);
      #1;
      send(5, 5, 0, 2'b00, 0, w);
      send(2, 5, 0, 2'b10, 0, w);
      send(3, 3, 0, 2'b10, 0, w);
      repeat (4) @(posedge clk);
      #1;
      chk("pre_rst_valid", 64'(ov_s), 64'd1);
      rstn = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(ov_s), 64'd0);
      chk("mid_rst_p", 64'(p_s), 64'd0);
      chk("mid_rst_cnt", 64'(cnt_s), 64'd0);
      chk("mid_rst_ovf", 64'(of_s), 64'd0);
      chk("mid_rst_ready", 64'(ir_s), 64'd1);
      rmode = 0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      send(4, 4, 0, 2'b10, 1, w);
      chk("first_accept", 64'(w), 64'd0);
      drain("t32");
      chk("t32_p", 64'(lp[0]), 64'd16);
      chk("t32_cnt", 64'(lc[0]), 64'd1);

      for (int i = 0; i < 8200; i++) begin
         send(131071, 131071, 0, 2'b10, (i == 8199), w);
      end
      drain("t30");
      wrap30 = 64'sd8200 * 64'sd17179607041 - TWO48;
      chk("t30_sat_p", 64'(lp[0]), 64'h0000_7FFF_FFFF_FFFF);
      chk("t30_sat_ovf", 64'(lo[0]), 64'd1);
      chk("t30_sat_cnt", 64'(lc[0]), 64'd8200);
      chk("t30_wrap_p", 64'(lp[1]), 64'(wrap30[47:0]));
      chk("t30_wrap_ovf", 64'(lo[1]), 64'd1);

      rmode = 2;
      for (int i = 0; i < 400; i++) begin
         ra = AW'($urandom());
         rb = BW'($urandom());
         rc = PW'({$urandom(), $urandom()});
         if (i % 3 == 0) begin
            ra = AW'($signed($urandom_range(0, 40)) - 20);
            rb = BW'($signed($urandom_range(0, 40)) - 20);
         end
         send(longint'(ra), longint'(rb), longint'(rc),
              2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), w);
      end
      send(1, 1, 0, 2'b10, 1, w);
      drain("rand");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
